// File: rtl/vec_mac_pkg.sv
// Shared widths and the per-beat tag for the vector multiply-accumulate engine.
package vec_mac_pkg;

    // Control bits that travel in step with each beat's data through the pipeline.
    typedef struct packed {
        logic valid;
        logic last;
        logic relu;
    } beat_tag_t;

    function automatic int w_prod(input int w_x, input int w_k);
        return w_x + w_k + 1;
    endfunction

    function automatic int w_tree(input int w_x, input int w_k, input int c);
        return w_prod(w_x, w_k) + $clog2(c);
    endfunction

    function automatic int w_acc_default(input int w_x, input int w_k, input int c);
        return w_x + w_k + $clog2(c) + 8;
    endfunction

endpackage

// File: rtl/vec_mac_acc_add_tree.sv
// Pipelined binary adder tree: one register level per halving, sharing a single enable.
module add_tree
    import vec_mac_pkg::*;
#(
    parameter int N    = 16,
    parameter int W_IN = 17
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic                                en_i,
    input  logic [N-1:0][W_IN-1:0]              data_i,
    input  beat_tag_t                           tag_i,
    output logic signed [W_IN+$clog2(N)-1:0]    data_o,
    output beat_tag_t                           tag_o
);
    localparam int L = $clog2(N);

    genvar gi, gj;
    for (gi = 0; gi < L; gi++) begin : g_lvl
        localparam int N_OUT = N >> (gi + 1);
        localparam int W_O   = W_IN + gi + 1;

        logic signed [W_O-2:0] src [2*N_OUT];
        beat_tag_t             src_tag;
        logic signed [W_O-1:0] sum_q [N_OUT];
        beat_tag_t             tag_q;

        if (gi == 0) begin : g_src
            for (gj = 0; gj < N; gj++) begin : g_in
                assign src[gj] = data_i[gj];
            end
            assign src_tag = tag_i;
        end else begin : g_src
            for (gj = 0; gj < 2*N_OUT; gj++) begin : g_in
                assign src[gj] = g_lvl[gi-1].sum_q[gj];
            end
            assign src_tag = g_lvl[gi-1].tag_q;
        end

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                tag_q <= '0;
                for (int j = 0; j < N_OUT; j++) sum_q[j] <= '0;
            end else if (en_i) begin
                tag_q <= src_tag;
                for (int j = 0; j < N_OUT; j++)
                    sum_q[j] <= W_O'(src[2*j]) + W_O'(src[2*j+1]);
            end
        end
    end

    assign data_o = g_lvl[L-1].sum_q[0];
    assign tag_o  = g_lvl[L-1].tag_q;

endmodule

// File: rtl/vec_mac_acc.sv
// Vector MAC: per-lane multiply, pipelined reduction, cross-beat accumulation with
// valid/ready flow control, optional ReLU and a sticky signed-overflow flag.
module vec_mac_acc
    import vec_mac_pkg::*;
#(
    parameter int C   = 16,
    parameter int W_X = 8,
    parameter int W_K = 8,
    parameter int W_A = w_acc_default(W_X, W_K, C)
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic                       s_last,
    input  logic                       signed_mode,
    input  logic                       relu_en,
    input  logic [C-1:0][W_X-1:0]      x,
    input  logic [C-1:0][W_K-1:0]      k,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic signed [W_A-1:0]      m_data,
    output logic                       m_ovf
);
    localparam int W_P = w_prod(W_X, W_K);
    localparam int W_T = w_tree(W_X, W_K, C);

    logic                    stall;
    logic [C-1:0][W_P-1:0]   prod_d, prod_q;
    beat_tag_t               tag_p_q, tag_t;
    logic signed [W_T-1:0]   tree_sum;
    logic signed [W_A-1:0]   sum_ext, acc_sum, acc_d, acc_q, m_data_q;
    logic                    ovf_now, ovf_d, ovf_q, first_q, m_valid_q, m_ovf_q;

    // The whole pipeline freezes while a finished result waits to be taken.
    assign stall   = m_valid_q & ~m_ready;
    assign s_ready = ~stall;

    genvar gi;
    for (gi = 0; gi < C; gi++) begin : g_lane
        logic signed [W_X:0] x_ext;
        logic signed [W_K:0] k_ext;
        assign x_ext      = {signed_mode & x[gi][W_X-1], x[gi]};
        assign k_ext      = {signed_mode & k[gi][W_K-1], k[gi]};
        assign prod_d[gi] = W_P'(x_ext) * W_P'(k_ext);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prod_q  <= '0;
            tag_p_q <= '0;
        end else if (!stall) begin
            prod_q        <= prod_d;
            tag_p_q.valid <= s_valid;
            tag_p_q.last  <= s_last;
            tag_p_q.relu  <= relu_en;
        end
    end

    add_tree #(
        .N    (C),
        .W_IN (W_P)
    ) u_tree (
        .clk    (clk),
        .rstn   (rstn),
        .en_i   (s_ready),
        .data_i (prod_q),
        .tag_i  (tag_p_q),
        .data_o (tree_sum),
        .tag_o  (tag_t)
    );

    assign sum_ext = W_A'(tree_sum);
    assign acc_sum = acc_q + sum_ext;
    assign ovf_now = (acc_q[W_A-1] == sum_ext[W_A-1]) && (acc_sum[W_A-1] != acc_q[W_A-1]);

    always_comb begin
        acc_d = first_q ? sum_ext : acc_sum;
        ovf_d = first_q ? 1'b0 : (ovf_q | ovf_now);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            first_q   <= 1'b1;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_ovf_q   <= 1'b0;
        end else if (!stall) begin
            // Not stalled means any held result is being consumed on this edge.
            m_valid_q <= tag_t.valid & tag_t.last;
            if (tag_t.valid) begin
                acc_q <= acc_d;
                if (tag_t.last) begin
                    m_data_q <= (tag_t.relu && acc_d[W_A-1]) ? '0 : acc_d;
                    m_ovf_q  <= ovf_d;
                    first_q  <= 1'b1;
                    ovf_q    <= 1'b0;
                end else begin
                    first_q  <= 1'b0;
                    ovf_q    <= ovf_d;
                end
            end
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_ovf   = m_ovf_q;

endmodule

// File: tb/tb_vec_mac_acc.sv
// Directed bench: a default-width instance and a W_A=20 instance share all inputs.
module tb_vec_mac_acc;
    localparam int C = 16;

    logic clk = 1'b0;
    logic rstn, s_valid, s_last, signed_mode, relu_en, m_ready;
    logic [C-1:0][7:0] x, k;
    logic s_ready_a, s_ready_b, m_valid_a, m_valid_b, m_ovf_a, m_ovf_b;
    logic signed [27:0] m_data_a;
    logic signed [19:0] m_data_b;

    int n_vec = 0;
    int n_err = 0;

    typedef struct { int d; logic o; } res_t;
    res_t q_a[$];
    res_t q_b[$];

    always #5 clk = ~clk;

    vec_mac_acc #(.C(C), .W_X(8), .W_K(8)) dut_a (
        .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready_a), .s_last(s_last),
        .signed_mode(signed_mode), .relu_en(relu_en), .x(x), .k(k),
        .m_valid(m_valid_a), .m_ready(m_ready), .m_data(m_data_a), .m_ovf(m_ovf_a)
    );

    vec_mac_acc #(.C(C), .W_X(8), .W_K(8), .W_A(20)) dut_b (
        .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready_b), .s_last(s_last),
        .signed_mode(signed_mode), .relu_en(relu_en), .x(x), .k(k),
        .m_valid(m_valid_b), .m_ready(m_ready), .m_data(m_data_b), .m_ovf(m_ovf_b)
    );

    // Inputs change 1 time unit after posedge, so negedge sees the values the next edge uses.
    always @(negedge clk) begin
        if (rstn === 1'b1 && m_ready === 1'b1) begin
            if (m_valid_a === 1'b1) q_a.push_back('{int'(m_data_a), m_ovf_a});
            if (m_valid_b === 1'b1) q_b.push_back('{int'(m_data_b), m_ovf_b});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] xv, input logic [7:0] kv,
                        input logic last, input logic sgn, input logic relu);
        logic rdy;
        int   n;
        x = {C{xv}};
        k = {C{kv}};
        s_last = last;
        signed_mode = sgn;
        relu_en = relu;
        s_valid = 1'b1;
        rdy = 1'b0;
        n = 0;
        while (!rdy && n < 100) begin
            @(negedge clk);
            rdy = (s_ready_a === 1'b1);
            @(posedge clk);
            #1;
            n++;
        end
        chk("beat_accepted", rdy, 1);
        s_valid = 1'b0;
    endtask

    task automatic get_result(input string tag, input int exp_a, input logic ovf_a,
                              input logic use_b, input int exp_b, input logic ovf_b);
        res_t r;
        int   n;
        n = 0;
        while ((q_a.size() == 0 || q_b.size() == 0) && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({tag, "_present"}, q_a.size() != 0, 1);
        if (q_a.size() != 0) begin
            r = q_a.pop_front();
            chk({tag, "_data"}, r.d, exp_a);
            chk({tag, "_ovf"}, r.o, ovf_a);
        end
        if (q_b.size() != 0) begin
            r = q_b.pop_front();
            if (use_b) begin
                chk({tag, "_w20_data"}, r.d, exp_b);
                chk({tag, "_w20_ovf"}, r.o, ovf_b);
            end
        end
        align();
    endtask

    initial begin
        rstn = 1'b0; s_valid = 1'b0; s_last = 1'b0; signed_mode = 1'b0;
        relu_en = 1'b0; m_ready = 1'b1; x = '0; k = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m_valid", m_valid_a, 0);
        chk("rst_m_data", m_data_a, 0);
        chk("rst_m_ovf", m_ovf_a, 0);
        chk("rst_s_ready", s_ready_a, 1);
        rstn = 1'b1;
        align();

        // Latency: the accept edge is edge 1; result must appear after edge 6, not edge 5.
        beat(8'd1, 8'd1, 1'b1, 1'b1, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("lat_edge5_m_valid", m_valid_a, 0);
        @(posedge clk);
        @(negedge clk);
        chk("lat_edge6_m_valid", m_valid_a, 1);
        chk("lat_edge6_m_data", m_data_a, 16);
        get_result("single_1x1", 16, 1'b0, 1'b1, 16, 1'b0);

        beat(8'd2, 8'd3, 1'b0, 1'b1, 1'b0);
        beat(8'd2, 8'd3, 1'b0, 1'b1, 1'b0);
        beat(8'd2, 8'd3, 1'b1, 1'b1, 1'b0);
        get_result("three_b2b", 288, 1'b0, 1'b1, 288, 1'b0);

        beat(8'd2, 8'd3, 1'b0, 1'b1, 1'b0);
        align();
        beat(8'd2, 8'd3, 1'b0, 1'b1, 1'b0);
        align();
        beat(8'd2, 8'd3, 1'b1, 1'b1, 1'b0);
        get_result("three_gaps", 288, 1'b0, 1'b1, 288, 1'b0);

        beat(8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0);
        get_result("ff_signed", 16, 1'b0, 1'b1, 16, 1'b0);
        beat(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
        get_result("ff_unsigned", 1040400, 1'b0, 1'b0, 0, 1'b0);
        beat(8'h80, 8'h80, 1'b1, 1'b1, 1'b0);
        get_result("m128_sq", 262144, 1'b0, 1'b1, 262144, 1'b0);

        beat(8'hFF, 8'h01, 1'b1, 1'b1, 1'b1);
        get_result("relu_on", 0, 1'b0, 1'b1, 0, 1'b0);
        beat(8'hFF, 8'h01, 1'b1, 1'b1, 1'b0);
        get_result("relu_off", -16, 1'b0, 1'b1, -16, 1'b0);

        // Backpressure: 8 single-beat products, output stalled 4 cycles mid-stream.
        fork
            begin
                for (int i = 0; i < 8; i++) beat(8'(i + 1), 8'd1, 1'b1, 1'b1, 1'b0);
            end
            begin
                repeat (7) align();
                m_ready = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    chk("bp_s_ready", s_ready_a, 0);
                    chk("bp_m_valid", m_valid_a, 1);
                    align();
                end
                m_ready = 1'b1;
            end
        join
        for (int i = 0; i < 8; i++)
            get_result($sformatf("bp%0d", i), 16 * (i + 1), 1'b0, 1'b1, 16 * (i + 1), 1'b0);
        repeat (10) align();
        chk("bp_no_dup", q_a.size(), 0);

        // Overflow on the W_A=20 instance; the wide instance holds the true value.
        beat(8'h80, 8'h80, 1'b0, 1'b1, 1'b0);
        beat(8'h80, 8'h80, 1'b1, 1'b1, 1'b0);
        get_result("ovf", 524288, 1'b0, 1'b1, -524288, 1'b1);
        beat(8'd1, 8'd1, 1'b1, 1'b1, 1'b0);
        get_result("after_ovf", 16, 1'b0, 1'b1, 16, 1'b0);

        // Reset with a held result and a partial product in flight.
        m_ready = 1'b0;
        beat(8'd1, 8'd1, 1'b1, 1'b1, 1'b0);
        beat(8'd2, 8'd3, 1'b0, 1'b1, 1'b0);
        repeat (8) align();
        @(negedge clk);
        chk("pre_rst_m_valid", m_valid_a, 1);
        #2;
        rstn = 1'b0;
        #1;
        chk("mid_rst_m_valid", m_valid_a, 0);
        chk("mid_rst_m_data", m_data_a, 0);
        chk("mid_rst_m_ovf", m_ovf_a, 0);
        chk("mid_rst_s_ready", s_ready_a, 1);
        align();
        rstn = 1'b1;
        m_ready = 1'b1;
        align();
        chk("rst_no_result", q_a.size(), 0);
        beat(8'd1, 8'd1, 1'b1, 1'b1, 1'b0);
        get_result("post_rst", 16, 1'b0, 1'b1, 16, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
